// File: rtl/seg_count_display.sv
// Multiplexed 4-digit 7-segment display of a 4-bit count (digits 0-1) and a BCD wrap counter (digits 2-3).
// Optional macro LEADING_ZERO_BLANK_EN blanks digit1 and digit3 when they are zero.
`timescale 1ns/1ps
module seg_count_display #(
    parameter int REFRESH_BITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_val,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       wrap_pulse
);

    localparam logic [REFRESH_BITS-1:0] REFRESH_ONE = REFRESH_BITS'(1);
    localparam logic [6:0]              SEG_BLANK   = 7'b1111111;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_e;

    digit_e                  digit_q, digit_d;
    logic [3:0]              cur_val_q, prev_val_q;
    logic [3:0]              wrap_ones_q, wrap_ones_d;
    logic [3:0]              wrap_tens_q, wrap_tens_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [3:0]              an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    wrap_pulse_q;
    logic                    wrap_det;
    logic                    tick;
    logic [3:0]              cur_ones, cur_tens;
    logic [3:0]              digit_val;
    logic                    digit_blank;

    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    encode = 7'b1000000;
            4'd1:    encode = 7'b1111001;
            4'd2:    encode = 7'b0100100;
            4'd3:    encode = 7'b0110000;
            4'd4:    encode = 7'b0011001;
            4'd5:    encode = 7'b0010010;
            4'd6:    encode = 7'b0000010;
            4'd7:    encode = 7'b1111000;
            4'd8:    encode = 7'b0000000;
            4'd9:    encode = 7'b0010000;
            default: encode = SEG_BLANK;
        endcase
    endfunction

    // Reset parks the scan on DIG3 so the first refresh tick lands on DIG0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_val_q    <= 4'd0;
            prev_val_q   <= 4'd0;
            wrap_ones_q  <= 4'd0;
            wrap_tens_q  <= 4'd0;
            refresh_q    <= '0;
            digit_q      <= DIG3;
            an_q         <= 4'b1111;
            seg_q        <= SEG_BLANK;
            wrap_pulse_q <= 1'b0;
        end else begin
            cur_val_q    <= in_val;
            prev_val_q   <= cur_val_q;
            wrap_ones_q  <= wrap_ones_d;
            wrap_tens_q  <= wrap_tens_d;
            refresh_q    <= refresh_d;
            digit_q      <= digit_d;
            wrap_pulse_q <= wrap_det;
            if (tick) begin
                an_q  <= an_d;
                seg_q <= seg_d;
            end
        end
    end

    always_comb begin
        wrap_det    = (prev_val_q == 4'd15) && (cur_val_q == 4'd0);
        tick        = &refresh_q;
        refresh_d   = refresh_q + REFRESH_ONE;
        wrap_ones_d = wrap_ones_q;
        wrap_tens_d = wrap_tens_q;
        if (wrap_det) begin
            if (wrap_ones_q == 4'd9) begin
                wrap_ones_d = 4'd0;
                wrap_tens_d = (wrap_tens_q == 4'd9) ? 4'd0 : wrap_tens_q + 4'd1;
            end else begin
                wrap_ones_d = wrap_ones_q + 4'd1;
            end
        end
        digit_d = digit_q;
        if (tick) begin
            case (digit_q)
                DIG0:    digit_d = DIG1;
                DIG1:    digit_d = DIG2;
                DIG2:    digit_d = DIG3;
                default: digit_d = DIG0;
            endcase
        end
    end

    // Digit contents are taken from the pre-edge registers, so a wrap coinciding
    // with a tick shows the old wrap count.
    always_comb begin
        cur_tens    = (cur_val_q >= 4'd10) ? 4'd1 : 4'd0;
        cur_ones    = (cur_val_q >= 4'd10) ? cur_val_q - 4'd10 : cur_val_q;
        digit_val   = 4'd0;
        digit_blank = 1'b0;
        an_d        = 4'b1111;
        case (digit_d)
            DIG0: begin
                digit_val = cur_ones;
                an_d      = 4'b1110;
            end
            DIG1: begin
                digit_val = cur_tens;
                an_d      = 4'b1101;
`ifdef LEADING_ZERO_BLANK_EN
                digit_blank = (cur_tens == 4'd0);
`endif
            end
            DIG2: begin
                digit_val = wrap_ones_q;
                an_d      = 4'b1011;
            end
            default: begin
                digit_val = wrap_tens_q;
                an_d      = 4'b0111;
`ifdef LEADING_ZERO_BLANK_EN
                digit_blank = (wrap_tens_q == 4'd0);
`endif
            end
        endcase
        seg_d = digit_blank ? SEG_BLANK : encode(digit_val);
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_seg_count_display.sv
// Scoreboard bench for seg_count_display with REFRESH_BITS=2: stimulus pushes per-edge
// expectations, a monitor pops and compares them one time step after each rising edge.
`timescale 1ns/1ps
module tb_seg_count_display;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] SEG_LZ    = 7'b1111111;
`else
    localparam logic [6:0] SEG_LZ    = 7'b1000000;
`endif

    typedef struct {
        logic       chkAn;
        logic [3:0] an;
        logic       chkSeg;
        logic [6:0] seg;
        logic       wp;
        string      name;
    } expect_t;

    logic       clk;
    logic       rst;
    logic [3:0] inVal;
    logic [6:0] seg;
    logic [3:0] an;
    logic       wrapPulse;

    expect_t expQ[$];
    expect_t monEntry;
    int      nCompares;
    int      nFails;

    seg_count_display #(.REFRESH_BITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_val     (inVal),
        .seg        (seg),
        .an         (an),
        .wrap_pulse (wrapPulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] segOf(input int d);
        case (d)
            0:       segOf = 7'b1000000;
            1:       segOf = 7'b1111001;
            2:       segOf = 7'b0100100;
            3:       segOf = 7'b0110000;
            4:       segOf = 7'b0011001;
            5:       segOf = 7'b0010010;
            6:       segOf = 7'b0000010;
            7:       segOf = 7'b1111000;
            8:       segOf = 7'b0000000;
            9:       segOf = 7'b0010000;
            default: segOf = 7'b1111111;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        nCompares++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // Drives one value sampled at the next rising edge and queues what that edge must produce.
    task automatic applyStimulus(input logic [3:0] v, input logic chkAn, input logic [3:0] expAn,
                                 input logic chkSeg, input logic [6:0] expSeg, input logic expWp,
                                 input string name);
        expect_t e;
        @(negedge clk);
        inVal    = v;
        e.chkAn  = chkAn;
        e.an     = expAn;
        e.chkSeg = chkSeg;
        e.seg    = expSeg;
        e.wp     = expWp;
        e.name   = name;
        expQ.push_back(e);
    endtask

    task automatic runRange(input int first, input int last, input logic [3:0] v,
                            input logic [3:0] expAn, input logic [6:0] expSeg, input logic expWp);
        for (int e = first; e <= last; e++)
            applyStimulus(v, 1'b1, expAn, 1'b1, expSeg, expWp, $sformatf("edge%0d", e));
    endtask

    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            monEntry = expQ.pop_front();
            checkOutput({monEntry.name, " wrap_pulse"}, {7'd0, wrapPulse}, {7'd0, monEntry.wp});
            if (monEntry.chkAn)
                checkOutput({monEntry.name, " an"}, {4'd0, an}, {4'd0, monEntry.an});
            if (monEntry.chkSeg)
                checkOutput({monEntry.name, " seg"}, {1'b0, seg}, {1'b0, monEntry.seg});
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] v;
        logic [3:0] expAn;
        logic [6:0] expSeg;
        logic       chkSeg;
        logic       wp;
        int         idx;
        int         cnt;

        nCompares = 0;
        nFails    = 0;
        rst       = 1'b0;
        inVal     = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset an", {4'd0, an}, 8'b0000_1111);
        checkOutput("reset seg", {1'b0, seg}, {1'b0, SEG_BLANK});
        checkOutput("reset wrap_pulse", {7'd0, wrapPulse}, 8'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        // Power-up scan, then in_val=12 across all four digits.
        runRange(1, 3, 4'd0, 4'b1111, SEG_BLANK, 1'b0);
        runRange(4, 4, 4'd0, 4'b1110, SEG_0, 1'b0);
        runRange(5, 7, 4'd12, 4'b1110, SEG_0, 1'b0);
        runRange(8, 11, 4'd12, 4'b1101, SEG_1, 1'b0);
        runRange(12, 15, 4'd12, 4'b1011, SEG_0, 1'b0);
        runRange(16, 19, 4'd12, 4'b0111, SEG_LZ, 1'b0);
        runRange(20, 20, 4'd12, 4'b1110, SEG_2, 1'b0);

        // 14,15,0,1: one wrap, pulse on edge 24, wrap count shows 1 on digit2.
        runRange(21, 21, 4'd14, 4'b1110, SEG_2, 1'b0);
        runRange(22, 22, 4'd15, 4'b1110, SEG_2, 1'b0);
        runRange(23, 23, 4'd0, 4'b1110, SEG_2, 1'b0);
        runRange(24, 24, 4'd1, 4'b1101, SEG_LZ, 1'b1);
        runRange(25, 27, 4'd1, 4'b1101, SEG_LZ, 1'b0);
        runRange(28, 28, 4'd1, 4'b1011, SEG_1, 1'b0);

        // 15->5 and 7->0 are not wraps; count stays 1.
        runRange(29, 29, 4'd15, 4'b1011, SEG_1, 1'b0);
        runRange(30, 30, 4'd5, 4'b1011, SEG_1, 1'b0);
        runRange(31, 31, 4'd7, 4'b1011, SEG_1, 1'b0);
        runRange(32, 35, 4'd0, 4'b0111, SEG_LZ, 1'b0);
        runRange(36, 39, 4'd0, 4'b1110, SEG_0, 1'b0);
        runRange(40, 43, 4'd0, 4'b1101, SEG_LZ, 1'b0);
        runRange(44, 44, 4'd0, 4'b1011, SEG_1, 1'b0);

        // Wrap coincides with the digit2 tick: display keeps the old count of 1.
        runRange(45, 47, 4'd0, 4'b1011, SEG_1, 1'b0);
        runRange(48, 51, 4'd0, 4'b0111, SEG_LZ, 1'b0);
        runRange(52, 55, 4'd0, 4'b1110, SEG_0, 1'b0);
        runRange(56, 57, 4'd0, 4'b1101, SEG_LZ, 1'b0);
        runRange(58, 58, 4'd15, 4'b1101, SEG_LZ, 1'b0);
        runRange(59, 59, 4'd0, 4'b1101, SEG_LZ, 1'b0);
        runRange(60, 60, 4'd0, 4'b1011, SEG_1, 1'b1);

        // Asynchronous reset while the pulse is high and digit2 is selected.
        @(posedge clk);
        #3;
        checkOutput("pre-reset wrap_pulse", {7'd0, wrapPulse}, 8'd1);
        checkOutput("pre-reset an", {4'd0, an}, 8'b0000_1011);
        rst = 1'b0;
        #1;
        checkOutput("async reset wrap_pulse", {7'd0, wrapPulse}, 8'd0);
        checkOutput("async reset an", {4'd0, an}, 8'b0000_1111);
        checkOutput("async reset seg", {1'b0, seg}, {1'b0, SEG_BLANK});
        repeat (2) @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;

        // 100 wraps from 15,0 pairs; pulse on odd edges 3..201, scan tick every 4th edge.
        for (int e = 1; e <= 208; e++) begin
            v      = (e <= 200 && (e % 2) == 1) ? 4'd15 : 4'd0;
            wp     = ((e % 2) == 1) && (e >= 3) && (e <= 201);
            idx    = 0;
            expAn  = 4'b1111;
            if (e >= 4) begin
                idx   = ((e / 4) - 1) % 4;
                expAn = ~(4'b0001 << idx);
            end
            chkSeg = ((e % 4) == 0) && (idx >= 2);
            cnt    = (e - 2) / 2;
            if (cnt > 100)
                cnt = 100;
            cnt    = cnt % 100;
            expSeg = SEG_BLANK;
            if (idx == 2)
                expSeg = segOf(cnt % 10);
            else if (idx == 3)
                expSeg = ((cnt / 10) == 0) ? SEG_LZ : segOf(cnt / 10);
            applyStimulus(v, 1'b1, expAn, chkSeg, expSeg, wp, $sformatf("wrap100 e%0d", e));
        end

        @(posedge clk);
        #2;
        checkOutput("scoreboard drained", 8'(expQ.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nCompares, nFails);
        $finish;
    end

endmodule

// File: doc/seg_count_display.md
SEG_COUNT_DISPLAY -- requirements
Module: seg_count_display

Interface
REQ-001 Parameter REFRESH_BITS, default 16, width of the digit-refresh divider; the bench sets 2.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset (0 = reset).
REQ-004 in_val  input  4  count value from the upstream 4-bit counter, unsigned 0..15.
REQ-005 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low, registered.
REQ-006 an  output  4  digit anode select, active-low one-hot, registered; an[0] is the rightmost digit.
REQ-007 wrap_pulse  output  1  one-cycle high pulse on each detected counter wrap, registered.

Function
REQ-008 in_val SHALL be sampled into cur_val every clk edge, and the previous cur_val SHALL be held in prev_val (1-cycle pipeline).
REQ-009 A wrap SHALL be detected when prev_val==15 and cur_val==0; wrap_pulse SHALL be 1 on the following cycle for exactly one cycle.
REQ-010 Only the exact 15->0 transition SHALL count as a wrap; a jump such as 15->5 or 7->0 SHALL NOT.
REQ-011 wrap_cnt SHALL be a 2-digit BCD counter (tens, ones) that increments by 1 on each wrap; 09->10 carries; 99->00 rolls over with no other effect.
REQ-012 Digit mapping: digit0 = ones of cur_val, digit1 = tens of cur_val (0 or 1), digit2 = ones of wrap_cnt, digit3 = tens of wrap_cnt.
REQ-013 A free-running REFRESH_BITS-wide counter SHALL increment every cycle; a refresh tick occurs when it equals all-ones, and it then wraps to 0.
REQ-014 On each tick, the digit index SHALL advance 0->1->2->3->0, and an and seg SHALL be loaded for the new index in the same edge.
REQ-015 an values: index0=1110, index1=1101, index2=1011, index3=0111; exactly one bit low at all times after the first tick.
REQ-016 seg encoding (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
REQ-017 seg SHALL reflect the digit value at the moment of the tick; value changes between ticks appear at that digit's next selection.
REQ-018 Simultaneous wrap and tick SHALL both take effect; the digit loaded shows the pre-increment wrap_cnt.

Reset
REQ-019 While rst=0: cur_val=0, prev_val=0, wrap_cnt=00, refresh counter=0, digit index=3, an=1111, seg=1111111, wrap_pulse=0.
REQ-020 Reset SHALL take effect immediately (asynchronous) including mid-refresh and mid-pulse; wrap_pulse SHALL drop at once.
REQ-021 After rst release, the first tick SHALL select index0; no wrap SHALL be reported from reset values.

Configuration
REQ-022 Macro LEADING_ZERO_BLANK_EN: when defined, digit1 and digit3 SHALL show blank when their value is 0; when undefined, they SHALL show 0 (1000000).
REQ-023 The macro SHALL NOT affect anode scan timing, wrap detection, or wrap_cnt.

Verification (REFRESH_BITS=2)
REQ-024 rst=0 then release, in_val=0 -> an=1111, seg=1111111 until 4th cycle after release, then an=1110, seg=1000000.
REQ-025 in_val=12 held, scan 4 digits -> index0 seg=0100100, index1 seg=1111001, index2 seg=1000000, index3 seg=1111111 with macro / 1000000 without.
REQ-026 in_val sequence 14,15,0,1 -> wrap_pulse high exactly one cycle, two edges after in_val=0 is applied; wrap_cnt=01.
REQ-027 in_val 15->5 and 7->0 -> wrap_pulse stays 0, wrap_cnt unchanged.
REQ-028 Apply 100 wraps (drive 15,0 pairs) -> wrap_cnt 09->10 carry seen, final value 00; digit3 shows blank/0 per macro.
REQ-029 Assert rst during wrap_pulse=1 and an=1011 -> wrap_pulse, an, seg go to reset values within same cycle without waiting for clk.
